// File: rtl/clock_gating_controller_pkg.sv
// Shared types and constants for clock_gating_controller.
//   - cgc_state_e    : controller state (ACTIVE / GATED / WAKING)
//   - WAKE_CNT_WIDTH : wake counter width for the default wake latency
//   - wake_cnt_width : the same width for any wake latency
package clock_gating_controller_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        GATED  = 2'd1,
        WAKING = 2'd2
    } cgc_state_e;

    localparam int unsigned DEFAULT_WAKE_LATENCY = 2;
    localparam int unsigned WAKE_CNT_WIDTH       = $clog2(DEFAULT_WAKE_LATENCY + 1);

    // Wake counter width for a given latency (never below one bit)
    function automatic int unsigned wake_cnt_width(input int unsigned latency);
        int unsigned w;
        w = $clog2(latency + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clock_gating_controller.sv
// clock_gating_controller: drives the enable of a downstream clock gater.
// It counts idle cycles, gates after idle_threshold idle cycles and ungates
// on activity or wake_request. wake_acknowledge rises WAKE_LATENCY cycles
// after enable returns high. The block runs on the free-running clock.
//
// Ports:
//   clock            in   free-running clock (gater clock_in)
//   reset            in   synchronous active-high reset
//   activity         in   block busy this cycle
//   idle_threshold   in   idle cycles before gating, 0 = never gate
//   wake_request     in   level request to ungate, held until acknowledged
//   wake_acknowledge out  gated clock running and stable
//   enable           out  gater enable
//   gated            out  controller is in GATED
//   gated_cycles     out  saturating count of GATED cycles
//                         (only with CLOCK_GATING_CONTROLLER_STATISTICS_EN)
//
// Build option: define CLOCK_GATING_CONTROLLER_STATISTICS_EN to add the
// gated_cycles counter, its output and the STATISTICS_WIDTH parameter.
module clock_gating_controller
    import clock_gating_controller_pkg::*;
#(
    parameter int unsigned IDLE_THRESHOLD_WIDTH = 8,
    parameter int unsigned WAKE_LATENCY         = DEFAULT_WAKE_LATENCY
`ifdef CLOCK_GATING_CONTROLLER_STATISTICS_EN
    ,
    parameter int unsigned STATISTICS_WIDTH     = 32
`endif
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            activity,
    input  logic [IDLE_THRESHOLD_WIDTH-1:0] idle_threshold,
    input  logic                            wake_request,
    output logic                            wake_acknowledge,
    output logic                            enable,
    output logic                            gated
`ifdef CLOCK_GATING_CONTROLLER_STATISTICS_EN
    ,
    output logic [STATISTICS_WIDTH-1:0]     gated_cycles
`endif
);

    localparam int unsigned ITW = IDLE_THRESHOLD_WIDTH;
    localparam int unsigned WCW = wake_cnt_width(WAKE_LATENCY);

    cgc_state_e     state_q, state_d;
    logic [ITW-1:0] idle_cnt_q, idle_cnt_d;
    logic [WCW-1:0] wake_cnt_q, wake_cnt_d;
    logic           enable_q, enable_d;
    logic           ack_q, ack_d;
    logic           gated_q, gated_d;

    logic wake_evt_c;
    logic at_threshold_c;
    logic wake_done_c;

    assign wake_evt_c = activity | wake_request;

    // >= rather than == so that lowering the threshold below the current
    // count still gates on the next idle cycle
    assign at_threshold_c = (idle_threshold != '0) &&
                            (idle_cnt_q >= (idle_threshold - ITW'(1)));

    assign wake_done_c = (wake_cnt_q == WCW'(WAKE_LATENCY - 1));

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            enable_q   <= 1'b1;
            ack_q      <= 1'b1;
            gated_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            enable_q   <= enable_d;
            ack_q      <= ack_d;
            gated_q    <= gated_d;
        end
    end

    // Next state; counters hold zero outside the state that uses them
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        unique case (state_q)
            ACTIVE: begin
                if (wake_evt_c) begin
                    idle_cnt_d = '0;
                end else if (at_threshold_c) begin
                    state_d = GATED;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + ITW'(1);
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
            end
            GATED: begin
                if (wake_evt_c) begin
                    state_d = WAKING;
                end
            end
            WAKING: begin
                // Wake events here are absorbed; only the latency counts
                if (wake_done_c) begin
                    state_d = ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q + WCW'(1);
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
    end

    // Outputs decoded from the next state so they register with it
    always_comb begin
        enable_d = 1'b1;
        ack_d    = 1'b1;
        gated_d  = 1'b0;
        unique case (state_d)
            ACTIVE: begin
                enable_d = 1'b1;
                ack_d    = 1'b1;
                gated_d  = 1'b0;
            end
            GATED: begin
                enable_d = 1'b0;
                ack_d    = 1'b0;
                gated_d  = 1'b1;
            end
            WAKING: begin
                enable_d = 1'b1;
                ack_d    = 1'b0;
                gated_d  = 1'b0;
            end
            default: begin
                enable_d = 1'b1;
                ack_d    = 1'b1;
                gated_d  = 1'b0;
            end
        endcase
    end

    assign enable           = enable_q;
    assign wake_acknowledge = ack_q;
    assign gated            = gated_q;

`ifdef CLOCK_GATING_CONTROLLER_STATISTICS_EN
    logic [STATISTICS_WIDTH-1:0] gated_cycles_q, gated_cycles_d;

    // Saturating count of cycles spent in GATED
    always_comb begin
        gated_cycles_d = gated_cycles_q;
        if ((state_q == GATED) && (gated_cycles_q != '1)) begin
            gated_cycles_d = gated_cycles_q + STATISTICS_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gated_cycles_q <= '0;
        end else begin
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign gated_cycles = gated_cycles_q;
`endif

endmodule

// File: tb/tb_clock_gating_controller.sv
// Directed testbench for clock_gating_controller with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_clock_gating_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       activity;
    logic [7:0] idle_threshold;
    logic       wake_request;
    logic       wake_acknowledge;
    logic       enable;
    logic       gated;
`ifdef CLOCK_GATING_CONTROLLER_STATISTICS_EN
    logic [31:0] gated_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    clock_gating_controller dut (
        .clock            (clock),
        .reset            (reset),
        .activity         (activity),
        .idle_threshold   (idle_threshold),
        .wake_request     (wake_request),
        .wake_acknowledge (wake_acknowledge),
        .enable           (enable),
        .gated            (gated)
`ifdef CLOCK_GATING_CONTROLLER_STATISTICS_EN
        ,
        .gated_cycles     (gated_cycles)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic en, input logic ack, input logic g);
        check_eq({tag, "_enable"}, 32'(enable), 32'(en));
        check_eq({tag, "_ack"},    32'(wake_acknowledge), 32'(ack));
        check_eq({tag, "_gated"},  32'(gated), 32'(g));
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic gate_seen;

        reset          = 1'b1;
        activity       = 1'b0;
        wake_request   = 1'b0;
        idle_threshold = 8'd4;
        tick();
        tick();
        check_out("reset", 1'b1, 1'b1, 1'b0);
        reset = 1'b0;

        // Four idle cycles at threshold 4: gate on the fourth sampling edge
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_out($sformatf("idle%0d", i), 1'b1, 1'b1, 1'b0);
        end
        tick();
        check_out("gate_at_thr", 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check_out("hold_gated", 1'b0, 1'b0, 1'b1);

        // One-cycle activity pulse wakes; ack WAKE_LATENCY (2) cycles after enable
        activity = 1'b1;
        tick();
        activity = 1'b0;
        check_out("wake1", 1'b1, 1'b0, 1'b0);
        tick();
        check_out("wake2", 1'b1, 1'b0, 1'b0);
        tick();
        check_out("wake_ack", 1'b1, 1'b1, 1'b0);

        // Activity every third cycle never lets the count reach the threshold
        for (int i = 0; i < 50; i++) begin
            activity = (i % 3 == 0);
            tick();
            check_eq("pulse_enable", 32'(enable), 32'd1);
        end
        activity = 1'b0;

        // Threshold 0 never gates, even with a saturated idle counter
        idle_threshold = 8'd0;
        gate_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!enable) gate_seen = 1'b1;
        end
        check_eq("thr0_no_gate", 32'(gate_seen), 32'd0);

        // Held wake_request in ACTIVE keeps ack high and the idle count at zero
        wake_request   = 1'b1;
        idle_threshold = 8'd4;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("req_active_ack", 32'(wake_acknowledge), 32'd1);
        end
        wake_request = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("req_cleared_cnt", 32'(enable), 32'd1);
        end
        tick();
        check_out("regate", 1'b0, 1'b0, 1'b1);

        // Reset while WAKING returns to ACTIVE with ack on the next edge
        wake_request = 1'b1;
        tick();
        check_out("req_waking", 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_out("reset_in_waking", 1'b1, 1'b1, 1'b0);
        reset        = 1'b0;
        wake_request = 1'b0;

        // Activity on the threshold cycle wins; gating restarts from zero
        for (int i = 0; i < 3; i++) tick();
        activity = 1'b1;
        tick();
        activity = 1'b0;
        check_out("act_on_thr", 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("after_act_enable", 32'(enable), 32'd1);
        end
        tick();
        check_out("gate_after_act", 1'b0, 1'b0, 1'b1);

        // Request and activity together from GATED act as one wake event
        activity     = 1'b1;
        wake_request = 1'b1;
        tick();
        activity = 1'b0;
        check_out("both_waking1", 1'b1, 1'b0, 1'b0);
        tick();
        check_out("both_waking2", 1'b1, 1'b0, 1'b0);
        tick();
        check_out("both_ack", 1'b1, 1'b1, 1'b0);
        wake_request = 1'b0;

        // Lowering the threshold below the current count gates on the next idle cycle
        idle_threshold = 8'd10;
        for (int i = 0; i < 6; i++) tick();
        check_eq("high_thr_enable", 32'(enable), 32'd1);
        idle_threshold = 8'd4;
        tick();
        check_out("lowered_thr_gate", 1'b0, 1'b0, 1'b1);

`ifdef CLOCK_GATING_CONTROLLER_STATISTICS_EN
        // Ten cycles in GATED, then wake: gated_cycles = 10; reset clears it
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("stats_reset0", gated_cycles, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 9; i++) tick();
        activity = 1'b1;
        tick();
        activity = 1'b0;
        tick();
        tick();
        check_eq("stats_count10", gated_cycles, 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("stats_reset", gated_cycles, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
